// File: rtl/multi_cycle_control.sv
// -----------------------------------------------------------------------------
// multi_cycle_control
//   Control FSM for a multi-cycle MIPS-subset datapath. It sequences
//   FETCH -> DECODE -> EXECUTE -> [MEM] -> [WRITEBACK] and owns the program
//   counter and the instruction register. Decoded datapath controls are held
//   in registers from DECODE until the next instruction is decoded.
//
// Ports
//   clock        in   sole clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   instr_in     in   [31:0] instruction word from instruction memory
//   mem_ready    in   completion strobe for fetch and data access
//   zero         in   ALU zero flag, sampled in MEM for branches
//   stage        out  [2:0] 0 FETCH,1 DECODE,2 EXECUTE,3 MEM,4 WRITEBACK,7 HALT
//   pc           out  [31:0] program counter
//   alu_op       out  [1:0] 00 R-type, 11 ADDI/LW/SW, 01 BEQ/BNE, 10 idle
//   alu_funct    out  [5:0] IR[5:0]
//   ALU_Src      out  1 selects sign-extended immediate
//   sign_extend  out  [31:0] IR[15:0] sign-extended
//   reg_dst      out  1 selects rd, 0 selects rt
//   reg_write    out  register-file write strobe
//   mem_to_reg   out  1 selects memory data for writeback
//   instr_read   out  instruction fetch request
//   data_read    out  data load request
//   data_write   out  data store request
//   halted       out  high in HALT
// -----------------------------------------------------------------------------
module multi_cycle_control (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] instr_in,
  input  logic        mem_ready,
  input  logic        zero,
  output logic [2:0]  stage,
  output logic [31:0] pc,
  output logic [1:0]  alu_op,
  output logic [5:0]  alu_funct,
  output logic        ALU_Src,
  output logic [31:0] sign_extend,
  output logic        reg_dst,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        instr_read,
  output logic        data_read,
  output logic        data_write,
  output logic        halted
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [1:0] ALU_RTYPE = 2'b00;
  localparam logic [1:0] ALU_ADD   = 2'b11;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_IDLE  = 2'b10;

  logic [2:0]  stage_q, stage_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [1:0]  alu_op_q, alu_op_d;
  logic [5:0]  alu_funct_q, alu_funct_d;
  logic        alu_src_q, alu_src_d;
  logic [31:0] sign_extend_q, sign_extend_d;
  logic        reg_dst_q, reg_dst_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  // Low from reset until the first clock edge after release, so no fetch
  // request is raised (or accepted) while reset is still being left.
  logic        run_q;

  logic [5:0] opcode;
  logic       is_rtype, is_addi, is_lw, is_sw, is_beq, is_bne;
  logic       is_branch, is_legal, branch_taken;

  // Decode always looks at IR: it is loaded at the end of FETCH and stays
  // constant for the rest of the instruction.
  assign opcode    = ir_q[31:26];
  assign is_rtype  = (opcode == OP_RTYPE);
  assign is_addi   = (opcode == OP_ADDI);
  assign is_lw     = (opcode == OP_LW);
  assign is_sw     = (opcode == OP_SW);
  assign is_beq    = (opcode == OP_BEQ);
  assign is_bne    = (opcode == OP_BNE);
  assign is_branch = is_beq | is_bne;
  assign is_legal  = is_rtype | is_addi | is_lw | is_sw | is_branch;
  assign branch_taken = (is_beq & zero) | (is_bne & ~zero);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    stage_d       = stage_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    alu_op_d      = alu_op_q;
    alu_funct_d   = alu_funct_q;
    alu_src_d     = alu_src_q;
    sign_extend_d = sign_extend_q;
    reg_dst_d     = reg_dst_q;
    mem_to_reg_d  = mem_to_reg_q;

    case (stage_q)
      S_FETCH: begin
        if (run_q && mem_ready) begin
          ir_d    = instr_in;
          pc_d    = pc_q + 32'd4;
          stage_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!is_legal) begin
          alu_op_d      = ALU_IDLE;
          alu_funct_d   = '0;
          alu_src_d     = 1'b0;
          sign_extend_d = '0;
          reg_dst_d     = 1'b0;
          mem_to_reg_d  = 1'b0;
          stage_d       = S_HALT;
        end else begin
          alu_op_d      = is_rtype ? ALU_RTYPE : (is_branch ? ALU_SUB : ALU_ADD);
          alu_funct_d   = ir_q[5:0];
          alu_src_d     = is_addi | is_lw | is_sw;
          sign_extend_d = {{16{ir_q[15]}}, ir_q[15:0]};
          reg_dst_d     = is_rtype;
          mem_to_reg_d  = is_lw;
          stage_d       = S_EXEC;
        end
      end
      S_EXEC: begin
        stage_d = (is_lw | is_sw | is_branch) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (is_branch) begin
          // pc already holds the incremented value; the add wraps mod 2^32.
          if (branch_taken) pc_d = pc_q + {sign_extend_q[29:0], 2'b00};
          stage_d = S_FETCH;
        end else if (mem_ready) begin
          stage_d = is_lw ? S_WB : S_FETCH;
        end
      end
      S_WB:    stage_d = S_FETCH;
      S_HALT:  stage_d = S_HALT;
      default: stage_d = S_HALT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_q       <= S_FETCH;
      pc_q          <= '0;
      ir_q          <= '0;
      alu_op_q      <= ALU_IDLE;
      alu_funct_q   <= '0;
      alu_src_q     <= 1'b0;
      sign_extend_q <= '0;
      reg_dst_q     <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      stage_q       <= stage_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      alu_op_q      <= alu_op_d;
      alu_funct_q   <= alu_funct_d;
      alu_src_q     <= alu_src_d;
      sign_extend_q <= sign_extend_d;
      reg_dst_q     <= reg_dst_d;
      mem_to_reg_q  <= mem_to_reg_d;
      run_q         <= 1'b1;
    end
  end

  // Strobes are pure functions of the registered state, so they are glitch-free
  // with respect to mem_ready and are mutually exclusive by construction.
  assign stage       = stage_q;
  assign pc          = pc_q;
  assign alu_op      = alu_op_q;
  assign alu_funct   = alu_funct_q;
  assign ALU_Src     = alu_src_q;
  assign sign_extend = sign_extend_q;
  assign reg_dst     = reg_dst_q;
  assign mem_to_reg  = mem_to_reg_q;
  assign instr_read  = run_q && (stage_q == S_FETCH);
  assign data_read   = (stage_q == S_MEM) && is_lw;
  assign data_write  = (stage_q == S_MEM) && is_sw;
  assign reg_write   = (stage_q == S_WB);
  assign halted      = (stage_q == S_HALT);

endmodule

// File: tb/tb_multi_cycle_control.sv
module tb_multi_cycle_control;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] instr_in;
  logic        mem_ready;
  logic        zero;
  logic [2:0]  stage;
  logic [31:0] pc;
  logic [1:0]  alu_op;
  logic [5:0]  alu_funct;
  logic        ALU_Src;
  logic [31:0] sign_extend;
  logic        reg_dst;
  logic        reg_write;
  logic        mem_to_reg;
  logic        instr_read;
  logic        data_read;
  logic        data_write;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  multi_cycle_control dut (
    .clock(clock), .reset_n(reset_n), .instr_in(instr_in),
    .mem_ready(mem_ready), .zero(zero), .stage(stage), .pc(pc),
    .alu_op(alu_op), .alu_funct(alu_funct), .ALU_Src(ALU_Src),
    .sign_extend(sign_extend), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .instr_read(instr_read), .data_read(data_read),
    .data_write(data_write), .halted(halted)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] name;
    logic [31:0] instr;
    int          fw;        // FETCH cycles with mem_ready low
    int          mw;        // MEM cycles with mem_ready low
    logic        z;
    logic [31:0] exp_pc;
    int          cycles;
    int          nir, ndr, ndw, nrw;
    logic [2:0]  end_stage;
    logic [1:0]  aop;
    logic [5:0]  funct;
    logic        src, rd, m2r;
    logic [31:0] sext;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one instruction from FETCH until the FSM is back in FETCH or in HALT,
  // counting strobe cycles, then compares against the vector.
  task automatic run_vec(input vec_t v);
    int cyc = 0, fc = 0, mc = 0, nex = 0;
    int nir = 0, ndr = 0, ndw = 0, nrw = 0, bad_excl = 0, unstable = 0;
    bit left = 0, have_ctrl = 0;
    logic [2:0] st;
    logic [47:0] ctrl, ctrl_now;
    string n;
    n = $sformatf("%0s", v.name);
    while (cyc < 200) begin
      st = stage;
      if (left && (st == 3'd0 || st == 3'd7)) break;
      if (st != 3'd0) left = 1;
      zero = v.z;
      case (st)
        3'd0: begin instr_in = v.instr; mem_ready = (fc >= v.fw); end
        3'd3: begin instr_in = 32'hDEADBEEF; mem_ready = (mc >= v.mw); end
        default: begin instr_in = 32'hDEADBEEF; mem_ready = 1'b1; end
      endcase
      @(negedge clock);
      nir += int'(instr_read); ndr += int'(data_read);
      ndw += int'(data_write); nrw += int'(reg_write);
      if ($countones({instr_read, data_read, data_write, reg_write}) > 1) bad_excl++;
      if (halted !== (stage == 3'd7)) bad_excl++;
      ctrl_now = {alu_op, alu_funct, ALU_Src, reg_dst, mem_to_reg, sign_extend, 5'd0};
      if (st == 3'd2 && !have_ctrl) begin ctrl = ctrl_now; have_ctrl = 1; end
      else if (have_ctrl && st != 3'd0 && ctrl_now !== ctrl) unstable++;
      if (st == 3'd2) nex++;
      @(posedge clock); #1;
      cyc++;
      if (st == 3'd0) fc++;
      if (st == 3'd3) mc++;
    end
    check({n, "_timeout"}, 32'(cyc >= 200), 32'd0);
    check({n, "_pc"}, pc, v.exp_pc);
    check({n, "_cycles"}, cyc, v.cycles);
    check({n, "_stage_end"}, 32'(stage), 32'(v.end_stage));
    check({n, "_exec_cycles"}, nex, (v.end_stage == 3'd7) ? 0 : 1);
    check({n, "_instr_read"}, nir, v.nir);
    check({n, "_data_read"}, ndr, v.ndr);
    check({n, "_data_write"}, ndw, v.ndw);
    check({n, "_reg_write"}, nrw, v.nrw);
    check({n, "_exclusive"}, bad_excl, 0);
    check({n, "_ctrl_stable"}, unstable, 0);
    check({n, "_alu_op"}, 32'(alu_op), 32'(v.aop));
    check({n, "_alu_funct"}, 32'(alu_funct), 32'(v.funct));
    check({n, "_alu_src"}, 32'(ALU_Src), 32'(v.src));
    check({n, "_reg_dst"}, 32'(reg_dst), 32'(v.rd));
    check({n, "_mem_to_reg"}, 32'(mem_to_reg), 32'(v.m2r));
    check({n, "_sign_ext"}, sign_extend, v.sext);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_stage"}, 32'(stage), 32'd0);
    check({tag, "_pc"}, pc, 32'd0);
    check({tag, "_alu_op"}, 32'(alu_op), 32'd2);
    check({tag, "_ctrl"}, {alu_funct, ALU_Src, reg_dst, mem_to_reg, halted}, 32'd0);
    check({tag, "_sign_ext"}, sign_extend, 32'd0);
    check({tag, "_strobes"}, {instr_read, data_read, data_write, reg_write}, 32'd0);
  endtask

  initial begin
    int bad, nrw, ndw, guard;
    //          name        instr         fw mw z  exp_pc        cyc ir dr dw rw end   aop    funct  s  rd m2r sext
    vecs[0]  = '{"add",     32'h012A4020, 0, 0, 0, 32'd4,        4, 1, 0, 0, 1, 3'd0, 2'b00, 6'h20, 0, 1, 0, 32'h00004020};
    vecs[1]  = '{"lw_wait", 32'h8D090010, 2, 3, 0, 32'd8,        10, 3, 4, 0, 1, 3'd0, 2'b11, 6'h10, 1, 0, 1, 32'h00000010};
    vecs[2]  = '{"beq_t",   32'h1109FFFE, 0, 0, 1, 32'd4,        4, 1, 0, 0, 0, 3'd0, 2'b01, 6'h3E, 0, 0, 0, 32'hFFFFFFFE};
    vecs[3]  = '{"addi",    32'h21290005, 0, 0, 0, 32'd8,        4, 1, 0, 0, 1, 3'd0, 2'b11, 6'h05, 1, 0, 0, 32'h00000005};
    vecs[4]  = '{"beq_nt",  32'h1109FFFE, 0, 0, 0, 32'd12,       4, 1, 0, 0, 0, 3'd0, 2'b01, 6'h3E, 0, 0, 0, 32'hFFFFFFFE};
    vecs[5]  = '{"bne_t",   32'h1509FFFF, 0, 0, 0, 32'd12,       4, 1, 0, 0, 0, 3'd0, 2'b01, 6'h3F, 0, 0, 0, 32'hFFFFFFFF};
    vecs[6]  = '{"bne_nt",  32'h1509FFFF, 0, 0, 1, 32'd16,       4, 1, 0, 0, 0, 3'd0, 2'b01, 6'h3F, 0, 0, 0, 32'hFFFFFFFF};
    vecs[7]  = '{"lw_fast", 32'h8D090010, 0, 0, 0, 32'd20,       5, 1, 1, 0, 1, 3'd0, 2'b11, 6'h10, 1, 0, 1, 32'h00000010};
    vecs[8]  = '{"sw",      32'hAD090004, 0, 0, 0, 32'd24,       4, 1, 0, 1, 0, 3'd0, 2'b11, 6'h04, 1, 0, 0, 32'h00000004};
    vecs[9]  = '{"beq_neg", 32'h1000FFF8, 0, 0, 1, 32'hFFFFFFFC, 4, 1, 0, 0, 0, 3'd0, 2'b01, 6'h38, 0, 0, 0, 32'hFFFFFFF8};
    vecs[10] = '{"addi_wr", 32'h21290005, 0, 0, 0, 32'd0,        4, 1, 0, 0, 1, 3'd0, 2'b11, 6'h05, 1, 0, 0, 32'h00000005};
    vecs[11] = '{"illegal", 32'hFC000000, 0, 0, 0, 32'd4,        2, 1, 0, 0, 0, 3'd7, 2'b10, 6'h00, 0, 0, 0, 32'h00000000};

    // Reset state, held over clock edges.
    reset_n = 1'b0; instr_in = 32'h0; mem_ready = 1'b1; zero = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_vals("rst");
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("rst_first_fetch_ir", 32'(instr_read), 32'd1);
    check("rst_first_fetch_pc", pc, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // HALT is absorbing and ignores mem_ready.
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0]; instr_in = 32'h012A4020;
      @(negedge clock);
      if (stage !== 3'd7 || halted !== 1'b1 || pc !== 32'd4 || alu_op !== 2'b10 ||
          {instr_read, data_read, data_write, reg_write} !== 4'b0) bad++;
      @(posedge clock); #1;
    end
    check("halt_hold_bad_cycles", bad, 0);

    // Asynchronous reset out of HALT, mid-cycle.
    #2 reset_n = 1'b0;
    #1 check_reset_vals("rst_halt");
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    check("rst_halt_fetch_ir", 32'(instr_read), 32'd1);

    // LW stalled in MEM, then aborted by reset.
    instr_in = 32'h8D090010; mem_ready = 1'b1;
    guard = 0;
    while (stage != 3'd3 && guard < 20) begin
      @(posedge clock); #1;
      mem_ready = 1'b0; instr_in = 32'h0;
      guard++;
    end
    check("lw_abort_reach_mem", 32'(guard < 20), 32'd1);
    repeat (2) @(posedge clock);
    #1 check("lw_abort_data_read", 32'(data_read), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("rst_mem");
    @(negedge clock) reset_n = 1'b1;
    nrw = 0; ndw = 0; bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      nrw += int'(reg_write); ndw += int'(data_write);
      if (stage !== 3'd0 || pc !== 32'd0 || instr_read !== 1'b1) bad++;
    end
    check("rst_mem_no_reg_write", nrw, 0);
    check("rst_mem_no_data_write", ndw, 0);
    check("rst_mem_fetch_pc0", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
